// File: rtl/fir_pkg.sv
// Shared types, default widths and width helper for the FIR MAC engine.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_COEF_W = 16;
  localparam int DEF_TAPS   = 4;

  // Full product width plus guard bits so that TAPS worst-case products never overflow.
  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// Processor/consumer-facing bundle of the FIR MAC engine: sample push,
// coefficient write, flush and the result valid/ready handshake.
interface fir_mac_engine_if #(
  parameter int DATA_W = fir_pkg::DEF_DATA_W,
  parameter int COEF_W = fir_pkg::DEF_COEF_W,
  parameter int TAPS   = fir_pkg::DEF_TAPS,
  parameter int ACC_W  = fir_pkg::acc_width(DATA_W, COEF_W, TAPS)
);

  localparam int ADDR_W = $clog2(TAPS);

  logic                     clear;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] sample_data;
  logic                     sample_ready;
  logic                     coeff_we;
  logic [ADDR_W-1:0]        coeff_addr;
  logic signed [COEF_W-1:0] coeff_data;
  logic                     busy;
  logic                     result_valid;
  logic signed [ACC_W-1:0]  result_data;
  logic                     result_ready;

  // Processor / consumer side.
  modport master (
    output clear, sample_valid, sample_data, coeff_we, coeff_addr, coeff_data, result_ready,
    input  sample_ready, busy, result_valid, result_data
  );

  // Engine side.
  modport slave (
    input  clear, sample_valid, sample_data, coeff_we, coeff_addr, coeff_data, result_ready,
    output sample_ready, busy, result_valid, result_data
  );

endinterface

// File: rtl/fir_mac_unit.sv
// Signed multiply, sign-extend to accumulator width, and accumulate.
// clr has priority over en; sum is the value the accumulator would take
// on an enabled edge, so the caller can capture the final tap sum directly.
module fir_mac_unit #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 34
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     clr,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] x,
  input  logic signed [COEF_W-1:0] c,
  output logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  sum
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  prod_ext_s;
  logic signed [ACC_W-1:0]  sum_s;
  logic signed [ACC_W-1:0]  acc_r;

  // Product, its sign extension and the next accumulator value.
  always_comb begin
    prod_s     = PROD_W'(x) * PROD_W'(c);
    prod_ext_s = {{(ACC_W - PROD_W){prod_s[PROD_W-1]}}, prod_s};
    sum_s      = acc_r + prod_ext_s;
  end

  // Accumulator register: cleared at the start of each computation, adds one tap when enabled.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= sum_s;
    end else begin
      acc_r <= acc_r;
    end
  end

  assign acc = acc_r;
  assign sum = sum_s;

endmodule

// File: rtl/fir_mac_engine.sv
// Sequential FIR engine: y[n] = sum_k c[k]*x[n-k] using one time-shared MAC.
// IDLE accepts a sample, MAC walks one tap per cycle, OUT holds the result
// until the consumer takes it. Coefficients are writable only in IDLE.
module fir_mac_engine
  import fir_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int COEF_W = DEF_COEF_W,
  parameter int TAPS   = DEF_TAPS,
  parameter int ACC_W  = acc_width(DATA_W, COEF_W, TAPS)
) (
  input logic       clock,
  input logic       reset,
  fir_mac_engine_if.slave bus
);

  localparam int TW = $clog2(TAPS);

  state_t                   state_r;
  logic [TW-1:0]            tap_r;
  logic                     sample_ready_r;
  logic                     busy_r;
  logic                     result_valid_r;
  logic signed [ACC_W-1:0]  result_data_r;
  logic signed [DATA_W-1:0] x_r    [TAPS];
  logic signed [COEF_W-1:0] coef_r [TAPS];

  logic                     accept_s;
  logic                     last_tap_s;
  logic                     coef_wr_s;
  logic                     mac_clr_s;
  logic                     mac_en_s;
  logic signed [DATA_W-1:0] x_sel_s;
  logic signed [COEF_W-1:0] c_sel_s;
  logic signed [ACC_W-1:0]  acc_s;
  logic signed [ACC_W-1:0]  sum_s;

  // Handshake decode, tap operand select and MAC controls. A flush blocks acceptance.
  always_comb begin
    accept_s   = bus.sample_valid && sample_ready_r && !bus.clear;
    last_tap_s = (tap_r == TW'(TAPS - 1));
    coef_wr_s  = bus.coeff_we && (state_r == IDLE);
    mac_clr_s  = bus.clear || accept_s;
    mac_en_s   = (state_r == MAC) && !bus.clear;
    x_sel_s    = x_r[tap_r];
    c_sel_s    = coef_r[tap_r];
  end

  fir_mac_unit #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .clock (clock),
    .reset (reset),
    .clr   (mac_clr_s),
    .en    (mac_en_s),
    .x     (x_sel_s),
    .c     (c_sel_s),
    .acc   (acc_s),
    .sum   (sum_s)
  );

  // Coefficient bank: cleared only by reset, written only while idle so a computation sees stable taps.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < TAPS; k++) coef_r[k] <= '0;
    end else if (coef_wr_s) begin
      coef_r[bus.coeff_addr] <= bus.coeff_data;
    end else begin
      for (int k = 0; k < TAPS; k++) coef_r[k] <= coef_r[k];
    end
  end

  // Control FSM with registered handshake outputs, tap counter, result register and delay line.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r        <= IDLE;
      tap_r          <= '0;
      sample_ready_r <= 1'b1;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_data_r  <= '0;
      for (int k = 0; k < TAPS; k++) x_r[k] <= '0;
    end else if (bus.clear) begin
      state_r        <= IDLE;
      tap_r          <= '0;
      sample_ready_r <= 1'b1;
      busy_r         <= 1'b0;
      result_valid_r <= 1'b0;
      result_data_r  <= '0;
      for (int k = 0; k < TAPS; k++) x_r[k] <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            for (int k = TAPS - 1; k > 0; k--) x_r[k] <= x_r[k-1];
            x_r[0]         <= bus.sample_data;
            tap_r          <= '0;
            state_r        <= MAC;
            sample_ready_r <= 1'b0;
            busy_r         <= 1'b1;
          end else begin
            state_r <= IDLE;
          end
        end
        MAC: begin
          if (last_tap_s) begin
            result_data_r  <= sum_s;
            result_valid_r <= 1'b1;
            state_r        <= OUT;
          end else begin
            tap_r <= tap_r + TW'(1);
          end
        end
        OUT: begin
          if (bus.result_ready) begin
            result_valid_r <= 1'b0;
            sample_ready_r <= 1'b1;
            busy_r         <= 1'b0;
            state_r        <= IDLE;
          end else begin
            state_r <= OUT;
          end
        end
        default: begin
          state_r        <= IDLE;
          tap_r          <= '0;
          sample_ready_r <= 1'b1;
          busy_r         <= 1'b0;
          result_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.sample_ready = sample_ready_r;
  assign bus.busy         = busy_r;
  assign bus.result_valid = result_valid_r;
  assign bus.result_data  = result_data_r;

endmodule
